// File: rtl/aes_key_schedule.sv
// ----------------------------------------------------------------------------
// aes_key_schedule
//   Iterative AES-128 key expansion. A cipher key is latched on an accepted
//   start. The engine then presents round keys 0..NUM_ROUNDS in order, and
//   each valid/ready handshake moves it on by one key. With rk_ready held high
//   it produces one new round key per cycle.
//
// Optional build macro: AES_KEY_SCHEDULE_STORE_EN
//   When defined, the block adds an 11-entry round-key store and a registered
//   read port.
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous reset, active low
//   start        request a new expansion (sampled only when idle)
//   key[127:0]   cipher key, key[127:96] is word 0
//   rk_ready     consumer accepts the presented round key
//   rk_valid     wo_0..wo_3 / rk_round hold a valid round key
//   rk_round     index of the presented round key
//   wo_0..wo_3   round-key words (MSB byte = row 0)
//   busy         expansion in progress
//   done         one-cycle pulse after the final key is accepted
//   rd_addr      (store build) round-key read address
//   rd_key       (store build) registered read data, 0 when out of range
//   keys_stored  (store build) full schedule held in the store
// ----------------------------------------------------------------------------

module sbox (
  input  logic [7:0] din,
  output logic [7:0] dout
);

  localparam logic [0:255][7:0] SBOX_TABLE = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign dout = SBOX_TABLE[din];

endmodule

module aes_key_schedule #(
  parameter int unsigned NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key,
  input  logic         rk_ready,
  output logic         rk_valid,
  output logic [3:0]   rk_round,
  output logic [31:0]  wo_0,
  output logic [31:0]  wo_1,
  output logic [31:0]  wo_2,
  output logic [31:0]  wo_3,
  output logic         busy,
  output logic         done
`ifdef AES_KEY_SCHEDULE_STORE_EN
  ,
  input  logic [3:0]   rd_addr,
  output logic [127:0] rd_key,
  output logic         keys_stored
`endif
);

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  rcon_q;
  logic [7:0]  rcon_next;
  logic [31:0] rot_word, sub_word, temp;
  logic [31:0] n0, n1, n2, n3;
  logic        load_key, advance, finish;

  // RotWord then SubWord on the last word of the current round key
  assign rot_word = {wo_3[23:0], wo_3[31:24]};

  sbox u_sbox0 (.din(rot_word[31:24]), .dout(sub_word[31:24]));
  sbox u_sbox1 (.din(rot_word[23:16]), .dout(sub_word[23:16]));
  sbox u_sbox2 (.din(rot_word[15:8]),  .dout(sub_word[15:8]));
  sbox u_sbox3 (.din(rot_word[7:0]),   .dout(sub_word[7:0]));

  assign temp = sub_word ^ {rcon_q, 24'h0};
  assign n0   = wo_0 ^ temp;
  assign n1   = wo_1 ^ n0;
  assign n2   = wo_2 ^ n1;
  assign n3   = wo_3 ^ n2;

  // xtime: multiply by x in GF(2^8), reducing by 0x11b (80 -> 1b)
  assign rcon_next = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);

  assign busy = (state_q != IDLE);

  always_comb begin
    state_d  = state_q;
    load_key = 1'b0;
    advance  = 1'b0;
    finish   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load_key = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (rk_ready) begin
          if (rk_round == LAST_ROUND) begin
            finish  = 1'b1;
            state_d = IDLE;
          end else begin
            advance = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rk_valid <= 1'b0;
      rk_round <= '0;
      wo_0     <= '0;
      wo_1     <= '0;
      wo_2     <= '0;
      wo_3     <= '0;
      rcon_q   <= 8'h01;
      done     <= 1'b0;
    end else begin
      done <= finish;
      if (load_key) begin
        wo_0     <= key[127:96];
        wo_1     <= key[95:64];
        wo_2     <= key[63:32];
        wo_3     <= key[31:0];
        rk_round <= '0;
        rk_valid <= 1'b1;
        rcon_q   <= 8'h01;
      end else if (advance) begin
        wo_0     <= n0;
        wo_1     <= n1;
        wo_2     <= n2;
        wo_3     <= n3;
        rk_round <= rk_round + 4'd1;
        rcon_q   <= rcon_next;
      end else if (finish) begin
        // words and round index keep the last key
        rk_valid <= 1'b0;
      end
    end
  end

`ifdef AES_KEY_SCHEDULE_STORE_EN
  logic [127:0] key_store [0:10];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < 11; i++) begin
        key_store[i] <= '0;
      end
      rd_key      <= '0;
      keys_stored <= 1'b0;
    end else begin
      if (rk_valid && rk_ready && (rk_round <= LAST_ROUND)) begin
        key_store[rk_round] <= {wo_0, wo_1, wo_2, wo_3};
      end
      rd_key <= (rd_addr <= LAST_ROUND) ? key_store[rd_addr] : '0;
      if (load_key) begin
        keys_stored <= 1'b0;
      end else if (finish) begin
        keys_stored <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_aes_key_schedule.sv
// ----------------------------------------------------------------------------
// tb_aes_key_schedule
//   Directed bench for aes_key_schedule: reset state, the FIPS-197 schedule,
//   a stall, an ignored start, a back-to-back start in the done cycle with
//   the all-zero key, and an asynchronous reset in the middle of a run.
//   The same source also covers the AES_KEY_SCHEDULE_STORE_EN build.
// ----------------------------------------------------------------------------

module tb_aes_key_schedule;

  logic         clk;
  logic         rst;
  logic         start;
  logic [127:0] key;
  logic         rk_ready;
  logic         rk_valid;
  logic [3:0]   rk_round;
  logic [31:0]  wo_0, wo_1, wo_2, wo_3;
  logic         busy;
  logic         done;
`ifdef AES_KEY_SCHEDULE_STORE_EN
  logic [3:0]   rd_addr;
  logic [127:0] rd_key;
  logic         keys_stored;
`endif

  logic [127:0] rk;
  logic [127:0] fips [0:10];
  int unsigned  n_assert;
  int unsigned  n_fail;

  assign rk = {wo_0, wo_1, wo_2, wo_3};

  aes_key_schedule #(.NUM_ROUNDS(10)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .key        (key),
    .rk_ready   (rk_ready),
    .rk_valid   (rk_valid),
    .rk_round   (rk_round),
    .wo_0       (wo_0),
    .wo_1       (wo_1),
    .wo_2       (wo_2),
    .wo_3       (wo_3),
    .busy       (busy),
    .done       (done)
`ifdef AES_KEY_SCHEDULE_STORE_EN
    ,
    .rd_addr    (rd_addr),
    .rd_key     (rd_key),
    .keys_stored(keys_stored)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_round(input string tag, input int r, input logic [127:0] exp);
    check($sformatf("%s_r%0d_idx", tag, r), {124'd0, rk_round}, 128'(r));
    check($sformatf("%s_r%0d_key", tag, r), rk, exp);
    check($sformatf("%s_r%0d_valid", tag, r), {127'd0, rk_valid}, 128'd1);
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    fips[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    fips[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fips[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fips[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fips[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fips[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fips[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fips[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fips[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fips[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fips[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    rst      = 1'b0;
    start    = 1'b0;
    key      = '0;
    rk_ready = 1'b0;
`ifdef AES_KEY_SCHEDULE_STORE_EN
    rd_addr  = '0;
`endif

    // reset state
    repeat (2) tick();
    check("rst_valid", {127'd0, rk_valid}, 128'd0);
    check("rst_round", {124'd0, rk_round}, 128'd0);
    check("rst_words", rk, 128'd0);
    check("rst_busy", {127'd0, busy}, 128'd0);
    check("rst_done", {127'd0, done}, 128'd0);
    rst = 1'b1;
    tick();
    // rk_ready while idle must not start anything
    rk_ready = 1'b1;
    tick();
    check("idle_ready_valid", {127'd0, rk_valid}, 128'd0);

    // FIPS-197 run, rk_ready held high
    start = 1'b1;
    key   = fips[0];
    tick();
    start = 1'b0;
    key   = '0;                       // key change during RUN has no effect
    check_round("fips", 0, fips[0]);
    check("fips_busy", {127'd0, busy}, 128'd1);
    for (int r = 1; r <= 10; r++) begin
      tick();
      check_round("fips", r, fips[r]);
      check($sformatf("fips_r%0d_done", r), {127'd0, done}, 128'd0);
    end
    tick();                           // 11th edge after start
    check("fips_done", {127'd0, done}, 128'd1);
    check("fips_end_valid", {127'd0, rk_valid}, 128'd0);
    check("fips_end_busy", {127'd0, busy}, 128'd0);
    check("fips_end_hold", rk, fips[10]);
`ifdef AES_KEY_SCHEDULE_STORE_EN
    check("store_flag", {127'd0, keys_stored}, 128'd1);
    rd_addr = 4'd10;
    tick();
    check("done_single", {127'd0, done}, 128'd0);
    check("store_rd10", rd_key, fips[10]);
    rd_addr = 4'd12;
    tick();
    check("store_rd12", rd_key, 128'd0);
    rd_addr = 4'd3;
    tick();
    check("store_rd3", rd_key, fips[3]);
`else
    tick();
    check("done_single", {127'd0, done}, 128'd0);
`endif

    // same key: ignored start at round 3, stall at round 5
    start = 1'b1;
    key   = fips[0];
    tick();
    start = 1'b0;
`ifdef AES_KEY_SCHEDULE_STORE_EN
    check("store_clr_on_start", {127'd0, keys_stored}, 128'd0);
`endif
    check_round("stall", 0, fips[0]);
    for (int r = 1; r <= 3; r++) begin
      tick();
      check_round("stall", r, fips[r]);
    end
    start = 1'b1;
    key   = '0;
    tick();
    start = 1'b0;
    key   = fips[0];
    check_round("ign_start", 4, fips[4]);
    check("ign_start_busy", {127'd0, busy}, 128'd1);
    tick();
    check_round("stall", 5, fips[5]);
    rk_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_round($sformatf("hold%0d", i), 5, fips[5]);
    end
    rk_ready = 1'b1;
    for (int r = 6; r <= 10; r++) begin
      tick();
      check_round("resume", r, fips[r]);
    end
    tick();
    check("stall_done", {127'd0, done}, 128'd1);

    // back-to-back start in the done cycle, all-zero key
    start = 1'b1;
    key   = '0;
    tick();
    start = 1'b0;
    check_round("zero", 0, 128'd0);
    check("zero_done_clr", {127'd0, done}, 128'd0);
    tick();
    check_round("zero", 1, 128'h62636363626363636263636362636363);
    for (int r = 2; r <= 10; r++) begin
      tick();
    end
    check_round("zero", 10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    tick();
    check("zero_done", {127'd0, done}, 128'd1);
    tick();

    // asynchronous reset in the middle of a run
    start = 1'b1;
    key   = fips[0];
    tick();
    start = 1'b0;
    for (int r = 1; r <= 4; r++) begin
      tick();
    end
    check_round("mid", 4, fips[4]);
    rst = 1'b0;
    #1;
    check("mid_rst_valid", {127'd0, rk_valid}, 128'd0);
    check("mid_rst_busy", {127'd0, busy}, 128'd0);
    check("mid_rst_done", {127'd0, done}, 128'd0);
    check("mid_rst_words", rk, 128'd0);
    check("mid_rst_round", {124'd0, rk_round}, 128'd0);
    tick();
    check("mid_rst_nodone", {127'd0, done}, 128'd0);
    rst = 1'b1;
    tick();
    check("post_rst_done", {127'd0, done}, 128'd0);
    check("post_rst_busy", {127'd0, busy}, 128'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_round("restart", 0, fips[0]);
    tick();
    check_round("restart", 1, fips[1]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_key_schedule.md
Name: aes_key_schedule

Overview:
- Iterative AES-128 key expansion engine. Sits directly upstream of the round datapath and supplies the four 32-bit round-key words per round.
- Latches a 128-bit cipher key on start. Emits round keys 0..NUM_ROUNDS in order, one per accepted handshake, with a valid/ready handshake and round index.
- Uses four instances of the existing sbox module for SubWord. One new round key is computed per cycle when not stalled.

Parameters:
- NUM_ROUNDS, 10: index of the last round key emitted. Legal range 1..10, bounded by the Rcon table. 10 gives standard AES-128.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset. Assertion clears all state immediately; deassertion is synchronised externally.
- start  input  1  request a new expansion; sampled only in IDLE.
- key  input  128  cipher key, sampled on the accepted start cycle. key[127:96] is word 0.
- rk_ready  input  1  consumer accepts the current round key.
- rk_valid  output  1  wo_0..wo_3 and rk_round hold a valid round key.
- rk_round  output  4  round index of the presented key, 0..NUM_ROUNDS.
- wo_0  output  32  round-key word 0 (bytes to column 0, MSB = row 0).
- wo_1  output  32  round-key word 1.
- wo_2  output  32  round-key word 2.
- wo_3  output  32  round-key word 3.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle pulse, the cycle after the final round key is accepted.

Behaviour:
- Reset values: rk_valid=0, rk_round=0, wo_0..wo_3=0, busy=0, done=0, state=IDLE, rcon register=8'h01.
- States:
  - IDLE -> RUN on a rising edge with start=1. In that edge: wo_0..wo_3 <= key words, rk_round <= 0, rk_valid <= 1, rcon <= 8'h01.
  - RUN, rk_ready=0: all outputs hold (stall). The key must stay stable while unaccepted.
  - RUN, rk_ready=1, rk_round < NUM_ROUNDS: load the next round key and increment rk_round. rk_valid stays 1, so back-to-back keys come one per cycle.
  - RUN, rk_ready=1, rk_round == NUM_ROUNDS: go to IDLE, rk_valid <= 0, done <= 1 for exactly one cycle. wo_* keep the last key.
- Next-key arithmetic:
  - temp = SubWord(RotWord(wo_3)) ^ {rcon, 24'h0}. RotWord({a,b,c,d}) = {b,c,d,a}; SubWord applies sbox to each byte.
  - n0 = wo_0 ^ temp; n1 = wo_1 ^ n0; n2 = wo_2 ^ n1; n3 = wo_3 ^ n2. All XOR is GF(2), no carries.
  - rcon advances by xtime on each accepted non-final key: 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36. After 80, xtime reduction gives 1b.
- Latency: first key valid 1 cycle after start is accepted. With rk_ready held high, the final key appears NUM_ROUNDS cycles later and done follows 1 cycle after that.
- Boundary conditions:
  - start while busy: ignored, no restart.
  - start in the same cycle that done is high: accepted; state is already IDLE.
  - rk_ready while rk_valid=0: ignored.
  - key changes during RUN: no effect.
  - rst asserted mid-expansion: immediate return to reset values. No done pulse. The next start begins again from round 0.

Optional Feature:
- Macro AES_KEY_SCHEDULE_STORE_EN.
- Defined:
  - Adds an 11x128 round-key register file written on every rk_valid&rk_ready handshake at address rk_round.
  - Adds ports rd_addr input 4, rd_key output 128 (registered, 1-cycle read latency) and keys_stored output 1.
  - keys_stored is set with done and cleared by reset or an accepted start.
  - rd_addr > NUM_ROUNDS returns 0.
  - The decrypt path and repeated encryptions under the same key then read keys without re-expansion.
- Undefined: none of these ports or storage exist. The core behaviour above is unchanged.

Test Plan:
- Reset: drive rst=0 mid-RUN at round 4 -> rk_valid, busy and done go 0 immediately, wo_*=0. After release, start with the FIPS-197 key restarts at round 0.
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1:
  - round 0 = key.
  - round 1 = a0fafe17 88542cb1 23a33939 2a6c7605.
  - round 10 = d014f9a8 c9ee2589 e13f0cc8 b6630ca6.
  - done pulses in cycle 12 after start.
- Stall: same key, drop rk_ready for 3 cycles while presenting round 5 -> outputs and rk_round=5 hold unchanged. Sequence resumes with round 6 and still matches the FIPS-197 schedule.
- Ignored start: pulse start with key 0 at round 3 -> the expansion continues with the original key. busy stays 1 and there is no restart.
- Back-to-back: assert start in the done cycle with all-zero key -> round 1 = 62636363 62636363 62636363 62636363 and round 10 = b4ef5bcb 3e92e211 23e951cf 6f8f188e.
- AES_KEY_SCHEDULE_STORE_EN build: after the FIPS-197 run, rd_addr=10 -> rd_key=d014f9a8c9ee2589e13f0cc8b6630ca6 one cycle later. rd_addr=12 -> 0.
